alu_test_sequencer: RTL and testbench
=====================================

Name: alu_test_sequencer

Overview:
Top-level self-test controller for the loader + RISC-V core pair. For each ALU opcode 0..NUM_OPS-1 it restarts the instruction loader, holds the core in reset until the program is written, then releases the core. It snoops the data-memory write port for the stored result, compares it against a golden value and accumulates pass/fail status. Sits beside the loader and core in the top wrapper and drives both of their active-low resets.

Parameters:
NUM_OPS, 4, number of ALU opcodes swept (alu_op 0..NUM_OPS-1); legal range 1..8
RUN_TIMEOUT, 64, max core cycles in RUN waiting for the result store
RESULT_ADDR, 32'h4, dmem byte address the test program stores the result to

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
start  in  1  single-cycle request; honoured only in IDLE
op1  in  12  operand 1; latched on accepted start
op2  in  12  operand 2; latched on accepted start
ldr_rst  out  1  active-low reset to loader
ldr_op1  out  12  latched op1 to loader
ldr_op2  out  12  latched op2 to loader
ldr_alu_op  out  3  current opcode index to loader
ldr_done  in  1  loader done flag
cpu_rst  out  1  active-low reset to core
dmem_we  in  1  core dmem write strobe (snooped)
dmem_addr  in  32  core dmem address (snooped)
dmem_wdata  in  32  core dmem write data (snooped)
busy  out  1  sweep in progress
done  out  1  sweep complete; held until next accepted start
pass_cnt  out  4  opcodes passed
fail_mask  out  NUM_OPS  bit i set = opcode i failed or timed out
timeout  out  1  sticky; any opcode timed out this sweep
last_result  out  32  most recent captured dmem_wdata

Behaviour:
- All outputs registered. Reset (rst=0 at clk edge): state IDLE, ldr_rst=0, cpu_rst=0, busy=0, done=0, pass_cnt=0, fail_mask=0, timeout=0, last_result=0, ldr_op1/ldr_op2/ldr_alu_op=0. Reset mid-sweep aborts immediately; no partial status retained.
- Golden: a=sext32(op1), b=sext32(op2). idx0 ADD a+b, idx1 SUB a-b (mod 2^32), idx2 AND, idx3 OR; idx>=4 expects a+b.
- FSM:
  IDLE: ldr_rst=0, cpu_rst=0. On start=1: latch ops, idx=0, clear pass_cnt/fail_mask/timeout/done, busy=1 -> LOAD.
  LOAD: ldr_rst=1, cpu_rst=0. On ldr_done=1 -> RELEASE.
  RELEASE: one cycle; cpu_rst=1, clear timeout counter -> RUN.
  RUN: count cycles. First cycle with dmem_we=1 && dmem_addr==RESULT_ADDR: capture dmem_wdata into last_result -> CHECK. Writes to other addresses ignored. Counter reaches RUN_TIMEOUT without match: set fail_mask[idx], timeout=1 -> NEXT. A match on the same cycle the counter expires counts as a match.
  CHECK: last_result==golden ? pass_cnt+1 : fail_mask[idx]=1 -> NEXT.
  NEXT: ldr_rst=0, cpu_rst=0 for exactly one cycle. If idx==NUM_OPS-1 -> FINISH, else idx+1 -> LOAD.
  FINISH: busy=0, done=1, both resets held low -> IDLE.
- start ignored while busy. op1/op2 changes while busy have no effect.
- Core reset is never released before ldr_done; loader is re-reset between opcodes so it restarts at address 0.
- Per-opcode latency (model core): 1 (LOAD entry) + 7 (loader) + 1 RELEASE + core run + 1 CHECK + 1 NEXT.

Optional Feature:
SEQ_STOP_ON_FAIL_EN defined: any failure or timeout in CHECK/RUN goes straight to FINISH; the remaining opcodes are skipped and their fail_mask bits stay 0. Undefined: all NUM_OPS opcodes always run.

Test Plan:
op1=5, op2=3, correct core model -> results 8, 2, 1, 7; pass_cnt=4, fail_mask=0, done=1, timeout=0.
op1=12'hFFF, op2=12'h001 -> results 0, 32'hFFFFFFFE, 1, 32'hFFFFFFFF; pass_cnt=4.
Model corrupts the SUB result (writes 3) -> fail_mask=4'b0010, pass_cnt=3; with SEQ_STOP_ON_FAIL_EN: done after idx1, pass_cnt=1.
Model never stores idx2 result -> RUN lasts 64 cycles, timeout=1, fail_mask=4'b0100; sweep continues to idx3.
Write to addr 8 before addr 4 -> first write ignored, addr-4 value checked; cpu_rst stays 0 until ldr_done each iteration.
rst=0 during RUN of idx1 -> next cycle: IDLE, all outputs at reset values; start pulsed while busy -> ignored, no counter clear.

Source files
------------

// File: rtl/alu_test_sequencer_if.sv
// Bundle of the sequencer's command, loader, core-snoop and status signals.
// The sequencer sits on the master side; the surrounding wrapper/environment uses slave.
interface alu_test_sequencer_if #(
    parameter int NUM_OPS = 4
);
    logic               start;
    logic [11:0]        op1;
    logic [11:0]        op2;
    logic               ldr_rst;
    logic [11:0]        ldr_op1;
    logic [11:0]        ldr_op2;
    logic [2:0]         ldr_alu_op;
    logic               ldr_done;
    logic               cpu_rst;
    logic               dmem_we;
    logic [31:0]        dmem_addr;
    logic [31:0]        dmem_wdata;
    logic               busy;
    logic               done;
    logic [3:0]         pass_cnt;
    logic [NUM_OPS-1:0] fail_mask;
    logic               timeout;
    logic [31:0]        last_result;

    modport master (
        input  start, op1, op2, ldr_done, dmem_we, dmem_addr, dmem_wdata,
        output ldr_rst, ldr_op1, ldr_op2, ldr_alu_op, cpu_rst,
               busy, done, pass_cnt, fail_mask, timeout, last_result
    );

    modport slave (
        output start, op1, op2, ldr_done, dmem_we, dmem_addr, dmem_wdata,
        input  ldr_rst, ldr_op1, ldr_op2, ldr_alu_op, cpu_rst,
               busy, done, pass_cnt, fail_mask, timeout, last_result
    );
endinterface

// File: rtl/alu_test_sequencer.sv
// ALU self-test sequencer: sweeps opcodes through loader + core and checks stored results.
// Optional macro SEQ_STOP_ON_FAIL_EN: abort the sweep at the first failure or timeout.
module alu_test_sequencer #(
    parameter int          NUM_OPS     = 4,
    parameter int          RUN_TIMEOUT = 64,
    parameter logic [31:0] RESULT_ADDR = 32'h4
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_test_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_CHECK, S_NEXT, S_FINISH
    } state_t;

    localparam int               CNT_W    = $clog2(RUN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_TIMEOUT - 1);
    localparam logic [2:0]       LAST_IDX = 3'(NUM_OPS - 1);
`ifdef SEQ_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    state_t             state_reg;
    logic [CNT_W-1:0]   run_cnt_reg;
    logic [11:0]        op1_reg, op2_reg;
    logic [2:0]         idx_reg;
    logic               ldr_rst_reg, cpu_rst_reg, busy_reg, done_reg, timeout_reg;
    logic [3:0]         pass_cnt_reg;
    logic [NUM_OPS-1:0] fail_mask_reg;
    logic [31:0]        last_result_reg;
    logic [NUM_OPS-1:0] idx_onehot;
    logic [31:0]        a_ext, b_ext, golden;

    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_onehot
        assign idx_onehot[gi] = (idx_reg == 3'(gi));
    end

    always_comb begin
        a_ext  = {{20{op1_reg[11]}}, op1_reg};
        b_ext  = {{20{op2_reg[11]}}, op2_reg};
        golden = a_ext + b_ext;
        case (idx_reg)
            3'd1:    golden = a_ext - b_ext;
            3'd2:    golden = a_ext & b_ext;
            3'd3:    golden = a_ext | b_ext;
            default: golden = a_ext + b_ext;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            run_cnt_reg     <= '0;
            op1_reg         <= '0;
            op2_reg         <= '0;
            idx_reg         <= '0;
            ldr_rst_reg     <= 1'b0;
            cpu_rst_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            timeout_reg     <= 1'b0;
            pass_cnt_reg    <= '0;
            fail_mask_reg   <= '0;
            last_result_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    ldr_rst_reg <= 1'b0;
                    cpu_rst_reg <= 1'b0;
                    if (bus.start) begin
                        op1_reg       <= bus.op1;
                        op2_reg       <= bus.op2;
                        idx_reg       <= '0;
                        pass_cnt_reg  <= '0;
                        fail_mask_reg <= '0;
                        timeout_reg   <= 1'b0;
                        done_reg      <= 1'b0;
                        busy_reg      <= 1'b1;
                        ldr_rst_reg   <= 1'b1;
                        state_reg     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Core stays in reset until the loader reports the program is written.
                    if (bus.ldr_done) begin
                        cpu_rst_reg <= 1'b1;
                        state_reg   <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    run_cnt_reg <= '0;
                    state_reg   <= S_RUN;
                end
                S_RUN: begin
                    if (bus.dmem_we && bus.dmem_addr == RESULT_ADDR) begin
                        last_result_reg <= bus.dmem_wdata;
                        state_reg       <= S_CHECK;
                    end else if (run_cnt_reg == RUN_LAST) begin
                        fail_mask_reg <= fail_mask_reg | idx_onehot;
                        timeout_reg   <= 1'b1;
                        ldr_rst_reg   <= 1'b0;
                        cpu_rst_reg   <= 1'b0;
                        if (STOP_ON_FAIL) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= S_FINISH;
                        end else begin
                            state_reg <= S_NEXT;
                        end
                    end else begin
                        run_cnt_reg <= run_cnt_reg + 1'b1;
                    end
                end
                S_CHECK: begin
                    ldr_rst_reg <= 1'b0;
                    cpu_rst_reg <= 1'b0;
                    if (last_result_reg == golden) begin
                        pass_cnt_reg <= pass_cnt_reg + 1'b1;
                        state_reg    <= S_NEXT;
                    end else begin
                        fail_mask_reg <= fail_mask_reg | idx_onehot;
                        if (STOP_ON_FAIL) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= S_FINISH;
                        end else begin
                            state_reg <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    // Both resets were low for this cycle, so the loader restarts at address 0.
                    if (idx_reg == LAST_IDX) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_FINISH;
                    end else begin
                        idx_reg     <= idx_reg + 1'b1;
                        ldr_rst_reg <= 1'b1;
                        state_reg   <= S_LOAD;
                    end
                end
                S_FINISH: begin
                    ldr_rst_reg <= 1'b0;
                    cpu_rst_reg <= 1'b0;
                    state_reg   <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.ldr_rst     = ldr_rst_reg;
    assign bus.cpu_rst     = cpu_rst_reg;
    assign bus.ldr_op1     = op1_reg;
    assign bus.ldr_op2     = op2_reg;
    assign bus.ldr_alu_op  = idx_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.pass_cnt    = pass_cnt_reg;
    assign bus.fail_mask   = fail_mask_reg;
    assign bus.timeout     = timeout_reg;
    assign bus.last_result = last_result_reg;
endmodule

// File: tb/tb_alu_test_sequencer.sv
// Self-checking bench: loader/core behavioural models plus a sweep-level reference model.
`timescale 1ns/1ps
module tb_alu_test_sequencer;
    localparam int NUM_OPS     = 4;
    localparam int RUN_TIMEOUT = 64;
    localparam int M_OK = 0, M_CORRUPT = 1, M_NOSTORE = 2, M_STRAY = 3;
`ifdef SEQ_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_test_sequencer_if #(.NUM_OPS(NUM_OPS)) bus();

    alu_test_sequencer #(
        .NUM_OPS(NUM_OPS), .RUN_TIMEOUT(RUN_TIMEOUT), .RESULT_ADDR(32'h4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          mode_q [NUM_OPS];
    logic [11:0] cur_op1, cur_op2;
    logic [31:0] exp_last;
    int          lcnt = 0, ccnt = 0, load_num = 0, early_rel = 0;
    int          hi_len [NUM_OPS];
    logic [2:0]  seen_alu_op [8];
    logic [11:0] seen_op1 [8];
    logic [11:0] seen_op2 [8];
    bit          cpu_rst_prev = 1'b0;
    bit          ldr_done_prev = 1'b0;

    function automatic logic [31:0] gold(input int i, input logic [11:0] x, input logic [11:0] y);
        int sa, sb;
        sa = int'($signed(x));
        sb = int'($signed(y));
        case (i)
            1:       return 32'(sa - sb);
            2:       return 32'(sa & sb);
            3:       return 32'(sa | sb);
            default: return 32'(sa + sb);
        endcase
    endfunction

    // Loader and core models, driven on the falling edge.
    always @(negedge clk) begin
        int idx, m;
        logic [31:0] g;
        if (!bus.ldr_rst) begin
            lcnt = 0;
            bus.ldr_done = 1'b0;
        end else begin
            if (lcnt < 7) lcnt++;
            bus.ldr_done = (lcnt == 7);
        end
        if (bus.ldr_done && !ldr_done_prev) begin
            if (load_num < 8) begin
                seen_alu_op[load_num] = bus.ldr_alu_op;
                seen_op1[load_num]    = bus.ldr_op1;
                seen_op2[load_num]    = bus.ldr_op2;
            end
            load_num++;
        end
        ldr_done_prev = bus.ldr_done;

        idx = int'(bus.ldr_alu_op);
        bus.dmem_we    = 1'b0;
        bus.dmem_addr  = 32'h0;
        bus.dmem_wdata = 32'h0;
        if (!bus.cpu_rst) begin
            if (cpu_rst_prev && idx < NUM_OPS) hi_len[idx] = ccnt;
            ccnt = 0;
        end else begin
            if (!cpu_rst_prev && !bus.ldr_done) early_rel++;
            ccnt++;
            m = (idx < NUM_OPS) ? mode_q[idx] : M_OK;
            g = gold(idx, cur_op1, cur_op2);
            if (ccnt == 3 && m == M_STRAY) begin
                bus.dmem_we = 1'b1; bus.dmem_addr = 32'h8; bus.dmem_wdata = ~g;
            end
            if (ccnt == 5 && m != M_NOSTORE) begin
                bus.dmem_we = 1'b1; bus.dmem_addr = 32'h4;
                bus.dmem_wdata = (m == M_CORRUPT) ? g + 32'd1 : g;
            end
        end
        cpu_rst_prev = bus.cpu_rst;
    end

    // Sweep-level reference: outcome of every opcode from its fault mode alone.
    task automatic model_sweep(input logic [11:0] a, input logic [11:0] b, output int e_pass,
                               output logic [NUM_OPS-1:0] e_mask, output logic e_tmo, output int e_runs);
        e_pass = 0; e_mask = '0; e_tmo = 1'b0; e_runs = 0;
        for (int i = 0; i < NUM_OPS; i++) begin
            bit failed;
            failed = 1'b0;
            e_runs++;
            case (mode_q[i])
                M_OK, M_STRAY: begin e_pass++; exp_last = gold(i, a, b); end
                M_CORRUPT:     begin e_mask[i] = 1'b1; failed = 1'b1; exp_last = gold(i, a, b) + 32'd1; end
                default:       begin e_mask[i] = 1'b1; e_tmo = 1'b1; failed = 1'b1; end
            endcase
            if (failed && STOP) break;
        end
    endtask

    task automatic run_sweep(input string name, input logic [11:0] a, input logic [11:0] b, input bit poke_busy);
        int e_pass, e_runs, waited;
        logic [NUM_OPS-1:0] e_mask;
        logic e_tmo;
        model_sweep(a, b, e_pass, e_mask, e_tmo, e_runs);
        cur_op1 = a; cur_op2 = b; load_num = 0; early_rel = 0;
        for (int i = 0; i < NUM_OPS; i++) hi_len[i] = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.op1 = a; bus.op2 = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op1 = ~a; bus.op2 = ~b;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_bad++; $display("FAIL %s start_accept: busy=%b done=%b expected busy=1 done=0", name, bus.busy, bus.done);
        end
        if (poke_busy) begin
            repeat (20) @(negedge clk);
            bus.start = 1'b1; bus.op1 = a ^ 12'h5A5; bus.op2 = b ^ 12'h3C3;
            @(negedge clk);
            bus.start = 1'b0;
        end
        waited = 0;
        while (bus.done !== 1'b1 && waited < 3000) begin @(negedge clk); waited++; end
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_bad++; $display("FAIL %s done_wait: done=%b after %0d cycles, expected 1", name, bus.done, waited);
        end
        n_cmp++;
        if (bus.pass_cnt !== 4'(e_pass)) begin
            n_bad++; $display("FAIL %s pass_cnt: got %0d expected %0d", name, bus.pass_cnt, e_pass);
        end
        n_cmp++;
        if (bus.fail_mask !== e_mask) begin
            n_bad++; $display("FAIL %s fail_mask: got %b expected %b", name, bus.fail_mask, e_mask);
        end
        n_cmp++;
        if (bus.timeout !== e_tmo) begin
            n_bad++; $display("FAIL %s timeout: got %b expected %b", name, bus.timeout, e_tmo);
        end
        n_cmp++;
        if (bus.last_result !== exp_last) begin
            n_bad++; $display("FAIL %s last_result: got %h expected %h", name, bus.last_result, exp_last);
        end
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.cpu_rst !== 1'b0 || bus.ldr_rst !== 1'b0) begin
            n_bad++; $display("FAIL %s finish_state: busy=%b cpu_rst=%b ldr_rst=%b expected all 0",
                              name, bus.busy, bus.cpu_rst, bus.ldr_rst);
        end
        n_cmp++;
        if (load_num !== e_runs || early_rel !== 0) begin
            n_bad++; $display("FAIL %s loads: got %0d loads %0d early releases, expected %0d loads 0 early",
                              name, load_num, early_rel, e_runs);
        end
        for (int i = 0; i < e_runs && i < 8; i++) begin
            n_cmp++;
            if (seen_alu_op[i] !== 3'(i) || seen_op1[i] !== a || seen_op2[i] !== b) begin
                n_bad++; $display("FAIL %s loader_args[%0d]: got op=%0d op1=%h op2=%h expected op=%0d op1=%h op2=%h",
                                  name, i, seen_alu_op[i], seen_op1[i], seen_op2[i], i, a, b);
            end
            if (mode_q[i] == M_NOSTORE) begin
                n_cmp++;
                if (hi_len[i] !== RUN_TIMEOUT + 1) begin
                    n_bad++; $display("FAIL %s run_len[%0d]: core released %0d cycles, expected %0d",
                                      name, i, hi_len[i], RUN_TIMEOUT + 1);
                end
            end
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_bad++; $display("FAIL %s done_hold: got %b expected 1", name, bus.done);
        end
        $display("sweep %-12s op1=%h op2=%h modes=%0d%0d%0d%0d pass=%0d mask=%b tmo=%b last=%h",
                 name, a, b, mode_q[0], mode_q[1], mode_q[2], mode_q[3],
                 bus.pass_cnt, bus.fail_mask, bus.timeout, bus.last_result);
    endtask

    task automatic set_modes(input int m0, input int m1, input int m2, input int m3);
        mode_q[0] = m0; mode_q[1] = m1; mode_q[2] = m2; mode_q[3] = m3;
    endtask

    task automatic check_all_reset(input string name);
        n_cmp++;
        if ({bus.ldr_rst, bus.cpu_rst, bus.busy, bus.done, bus.timeout, bus.pass_cnt, bus.fail_mask,
             bus.last_result, bus.ldr_op1, bus.ldr_op2, bus.ldr_alu_op} !== '0) begin
            n_bad++; $display("FAIL %s reset_values: ldr_rst=%b cpu_rst=%b busy=%b done=%b tmo=%b pass=%0d mask=%b last=%h op1=%h op2=%h alu_op=%0d expected all 0",
                              name, bus.ldr_rst, bus.cpu_rst, bus.busy, bus.done, bus.timeout, bus.pass_cnt,
                              bus.fail_mask, bus.last_result, bus.ldr_op1, bus.ldr_op2, bus.ldr_alu_op);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_reset("reset");
        exp_last = 32'h0;
        rst = 1'b1;
        $display("reset applied and released");
    endtask

    task automatic test_directed_pass();
        set_modes(M_OK, M_OK, M_OK, M_OK);
        run_sweep("pos_ops", 12'd5, 12'd3, 1'b0);
        run_sweep("neg_ops", 12'hFFF, 12'h001, 1'b0);
    endtask

    task automatic test_corrupt_sub();
        set_modes(M_OK, M_CORRUPT, M_OK, M_OK);
        run_sweep("corrupt_sub", 12'd5, 12'd3, 1'b0);
    endtask

    task automatic test_timeout();
        set_modes(M_OK, M_OK, M_NOSTORE, M_OK);
        run_sweep("timeout_op2", 12'd9, 12'd4, 1'b0);
    endtask

    task automatic test_stray_write();
        set_modes(M_STRAY, M_STRAY, M_STRAY, M_STRAY);
        run_sweep("stray_write", 12'h123, 12'h876, 1'b0);
    endtask

    task automatic test_busy_start_ignored();
        set_modes(M_OK, M_OK, M_OK, M_OK);
        run_sweep("busy_start", 12'(($urandom)), 12'(($urandom)), 1'b1);
    endtask

    task automatic test_back_to_back_random();
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                int r;
                r = int'($urandom_range(0, 9));
                mode_q[i] = (r < 6) ? M_OK : (r == 6) ? M_STRAY : (r < 9) ? M_CORRUPT : M_NOSTORE;
            end
            run_sweep($sformatf("random%0d", n), 12'($urandom), 12'($urandom), 1'b0);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int waited;
        set_modes(M_OK, M_NOSTORE, M_OK, M_OK);
        cur_op1 = 12'd7; cur_op2 = 12'd2;
        @(negedge clk);
        bus.start = 1'b1; bus.op1 = cur_op1; bus.op2 = cur_op2;
        @(negedge clk);
        bus.start = 1'b0;
        waited = 0;
        while (!(bus.ldr_alu_op == 3'd1 && bus.cpu_rst == 1'b1) && waited < 500) begin
            @(negedge clk); waited++;
        end
        n_cmp++;
        if (!(bus.ldr_alu_op == 3'd1 && bus.cpu_rst == 1'b1)) begin
            n_bad++; $display("FAIL mid_reset reach_run1: alu_op=%0d cpu_rst=%b expected 1 and 1",
                              bus.ldr_alu_op, bus.cpu_rst);
        end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_reset("mid_reset");
        rst = 1'b1;
        exp_last = 32'h0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.ldr_rst !== 1'b0 || bus.cpu_rst !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset stay_idle: busy=%b ldr_rst=%b cpu_rst=%b expected all 0",
                              bus.busy, bus.ldr_rst, bus.cpu_rst);
        end
        $display("mid-sweep reset during RUN of opcode 1 handled");
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op1   = 12'h0;
        bus.op2   = 12'h0;
        for (int i = 0; i < NUM_OPS; i++) mode_q[i] = M_OK;
        cur_op1 = 12'h0; cur_op2 = 12'h0; exp_last = 32'h0;
        test_reset();
        test_directed_pass();
        test_corrupt_sub();
        test_timeout();
        test_stray_write();
        test_busy_start_ignored();
        test_back_to_back_random();
        test_reset_mid_sweep();
        set_modes(M_OK, M_OK, M_OK, M_OK);
        run_sweep("after_reset", 12'h7FF, 12'h800, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
